// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : operation encodings as driven on the op port
//   state_e : controller states (IDLE, CALC, FIX, DONE)
//   helpers : decode of the signed and divide attributes of an op
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle of mul_div_unit.
//   start, cancel, op, a, b      : requester -> unit
//   busy, done, hi, lo,
//   div_by_zero                  : unit -> requester
// master = requester side, slave = unit side.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, cancel, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, cancel, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate.
//   neg_i : 1 = negate val_i, 0 = pass through
//   val_i : WIDTH-bit operand
//   val_o : WIDTH-bit result
// Used both to take operand magnitudes and to restore result signs.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : mul_div_unit_if slave (start/cancel/op/a/b in,
//              busy/done/hi/lo/div_by_zero out)
// Operation: start latches op/a/b in IDLE or DONE; CALC runs WIDTH
// shift-add (multiply) or restoring shift-subtract (divide) steps on
// operand magnitudes; FIX restores signs; DONE pulses done for a cycle.
// Divide datapath is built only when MUL_DIV_UNIT_DIV_EN is defined;
// otherwise divide ops complete immediately with zero results.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  op_e              op_in;
  logic             neg_a, neg_b, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_fixed;

  assign op_in  = op_e'(bus.op);
  assign neg_a  = op_is_signed(op_in) & bus.a[WIDTH-1];
  assign neg_b  = op_is_signed(op_in) & bus.b[WIDTH-1];
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .neg_i(neg_a), .val_i(bus.a), .val_o(mag_a)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .neg_i(neg_b), .val_i(bus.b), .val_o(mag_b)
  );

  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg_i(sa_q ^ sb_q), .val_i({acc_q, q_q}), .val_o(prod_fixed)
  );

  // Multiply: acc holds the running high half, q the multiplier that
  // shifts out LSB-first while product bits shift in from the top.
  assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : '0);

`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] quo_fixed, rem_fixed;

  // Divide: acc is the partial remainder, q the dividend shifting out
  // MSB-first while quotient bits shift in at the bottom.
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i(sa_q ^ sb_q), .val_i(q_q), .val_o(quo_fixed)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i(sa_q), .val_i(acc_q), .val_o(rem_fixed)
  );
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    q_d     = q_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;

    if (bus.cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        CALC: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
`ifdef MUL_DIV_UNIT_DIV_EN
          if (op_is_div(op_q)) begin
            acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
          end
`else
          acc_d = mul_sum[WIDTH:1];
          q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
`endif
        end
        FIX: begin
          state_d = DONE;
`ifdef MUL_DIV_UNIT_DIV_EN
          if (op_is_div(op_q)) begin
            hi_d = rem_fixed;
            lo_d = quo_fixed;
          end else begin
            {hi_d, lo_d} = prod_fixed;
          end
`else
          {hi_d, lo_d} = prod_fixed;
`endif
        end
        DONE:    state_d = IDLE;
        default: ;
      endcase

      // Accepting in DONE overrides the DONE->IDLE transition above.
      if (accept) begin
        state_d = CALC;
        op_d    = op_in;
        sa_d    = neg_a;
        sb_d    = neg_b;
        acc_d   = '0;
        cnt_d   = CW'(WIDTH - 1);
        dbz_d   = 1'b0;
        if (op_is_div(op_in)) begin
`ifdef MUL_DIV_UNIT_DIV_EN
          if (bus.b == '0) begin
            state_d = DONE;
            hi_d    = bus.a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            q_d    = mag_a;
            opnd_d = mag_b;
          end
`else
          state_d = DONE;
          hi_d    = '0;
          lo_d    = '0;
`endif
        end else begin
          q_d    = mag_b;
          opnd_d = mag_a;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULTU;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy        = (state_q == CALC) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
